fetch_ctrl: RTL

//  Instruction-fetch sequencer for the CPU. Owns the program counter, drives the address of the

---
 rtl/cpu_pkg.sv | 17 +
 rtl/ret_stack.sv | 47 ++++
 rtl/fetch_ctrl.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cpu_pkg: shared constants and fetch FSM state encodings               |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package cpu_pkg;
  localparam int c_pc_w    = 10;
  localparam int c_err_unf = 0;
  localparam int c_err_ovf = 1;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;
endpackage
`default_nettype wire

// File: rtl/ret_stack.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ret_stack: LIFO of return addresses, push/pop never issued together  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module ret_stack #(
  parameter int AW     = 10,
  parameter int SDEPTH = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] din,
  output logic [AW-1:0] top,
  output logic          full,
  output logic          empty
);
  localparam int c_pw = $clog2(SDEPTH);

  logic [AW-1:0] r_mem [SDEPTH];
  logic [c_pw:0] r_sp;
  logic [c_pw-1:0] w_top_idx;

  assign w_top_idx = c_pw'(r_sp - (c_pw+1)'(1));
  assign top       = r_mem[w_top_idx];
  assign full      = (r_sp == (c_pw+1)'(SDEPTH));
  assign empty     = (r_sp == '0);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sp <= '0;
    end else if (push) begin
      r_sp <= r_sp + (c_pw+1)'(1);
    end else if (pop) begin
      r_sp <= r_sp - (c_pw+1)'(1);
    end
  end

  // Storage is not reset; only the pointer defines what is valid.
  always_ff @(posedge clk) begin
    if (reset_n && push) begin
      r_mem[r_sp[c_pw-1:0]] <= din;
    end
  end
endmodule
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_ctrl: PC sequencer, instruction register and return stack      |
// | Optional interrupt entry enabled by FETCH_IRQ_EN.  Rev 1.0           |
// +----------------------------------------------------------------------+
module fetch_ctrl
  import cpu_pkg::*;
#(
  parameter int AW     = c_pc_w,
  parameter int DW     = 16,
  parameter int SDEPTH = 4
`ifdef FETCH_IRQ_EN
  ,
  parameter logic [AW-1:0] IRQ_VEC = 10'h3F0
`endif
) (
  input  logic          clk,
  input  logic          reset_n,
  output logic [AW-1:0] pm_addr,
  input  logic [DW-1:0] pm_rd,
  output logic [DW-1:0] instr,
  output logic          instr_valid,
  output logic [AW-1:0] pc_out,
  input  logic          stall,
  input  logic          jump,
  input  logic [AW-1:0] jump_addr,
  input  logic          branch,
  input  logic [7:0]    br_off,
  input  logic          call,
  input  logic          ret,
`ifdef FETCH_IRQ_EN
  input  logic          irq,
  output logic          irq_ack,
`endif
  output logic          halted,
  output logic [1:0]    err
);
  localparam logic [AW-1:0] c_one = AW'(1);

  fetch_state_t  r_state, w_state_nxt;
  logic [AW-1:0] r_pc, w_pc_nxt;
  logic [AW-1:0] r_pc_out;
  logic [DW-1:0] r_instr;
  logic          r_valid, w_valid_nxt;
  logic [1:0]    r_err, w_err_set;
  logic          w_load, w_push, w_pop;
  logic [AW-1:0] w_push_data, w_top, w_br_ext;
  logic          w_full, w_empty;
`ifdef FETCH_IRQ_EN
  logic          r_in_isr, w_in_isr_nxt;
  logic          r_irq_ack, w_irq_ack_nxt;
  assign irq_ack = r_irq_ack;
`endif

  assign w_br_ext    = {{(AW-8){br_off[7]}}, br_off};
  assign pm_addr     = r_pc;
  assign instr       = r_instr;
  assign instr_valid = r_valid;
  assign pc_out      = r_pc_out;
  assign halted      = (r_state == HALT);
  assign err         = r_err;

  ret_stack #(.AW(AW), .SDEPTH(SDEPTH)) u_ret_stack (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (w_push),
    .pop     (w_pop),
    .din     (w_push_data),
    .top     (w_top),
    .full    (w_full),
    .empty   (w_empty)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_valid_nxt = r_valid;
    w_load      = 1'b0;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_push_data = r_pc_out + c_one;
    w_err_set   = 2'b00;
`ifdef FETCH_IRQ_EN
    w_in_isr_nxt  = r_in_isr;
    w_irq_ack_nxt = 1'b0;
`endif
    case (r_state)
      HALT: w_valid_nxt = 1'b0;
      default: begin
        // BOOT is a plain fetch of address 0 with nothing valid to act on.
        if (!stall) begin
          w_state_nxt = RUN;
          w_load      = 1'b1;
          w_pc_nxt    = r_pc + c_one;
          w_valid_nxt = 1'b1;
          if (r_valid) begin
            if (ret) begin
              if (w_empty) begin
                w_err_set[c_err_unf] = 1'b1;
              end else begin
                w_pop       = 1'b1;
                w_pc_nxt    = w_top;
                w_valid_nxt = 1'b0;
`ifdef FETCH_IRQ_EN
                w_in_isr_nxt = 1'b0;
`endif
              end
            end else if (call) begin
              if (w_full) begin
                w_err_set[c_err_ovf] = 1'b1;
              end else begin
                w_push      = 1'b1;
                w_pc_nxt    = jump_addr;
                w_valid_nxt = 1'b0;
              end
            end else if (jump) begin
              w_pc_nxt    = jump_addr;
              w_valid_nxt = 1'b0;
            end else if (branch) begin
              w_pc_nxt    = r_pc_out + w_br_ext;
              w_valid_nxt = 1'b0;
            end
`ifdef FETCH_IRQ_EN
            else if (irq && !r_in_isr) begin
              if (w_full) begin
                w_err_set[c_err_ovf] = 1'b1;
              end else begin
                w_push        = 1'b1;
                w_push_data   = r_pc;
                w_pc_nxt      = IRQ_VEC;
                w_valid_nxt   = 1'b0;
                w_in_isr_nxt  = 1'b1;
                w_irq_ack_nxt = 1'b1;
              end
            end
`endif
          end
        end
      end
    endcase
    // A stack fault freezes the fetch path where it stands.
    if (w_err_set != 2'b00) begin
      w_state_nxt = HALT;
      w_pc_nxt    = r_pc;
      w_valid_nxt = 1'b0;
      w_load      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state  <= BOOT;
      r_pc     <= '0;
      r_pc_out <= '0;
      r_instr  <= '0;
      r_valid  <= 1'b0;
      r_err    <= 2'b00;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_valid <= w_valid_nxt;
      r_err   <= r_err | w_err_set;
      if (w_load) begin
        r_instr  <= pm_rd;
        r_pc_out <= r_pc;
      end
    end
  end

`ifdef FETCH_IRQ_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_in_isr  <= 1'b0;
      r_irq_ack <= 1'b0;
    end else begin
      r_in_isr  <= w_in_isr_nxt;
      r_irq_ack <= w_irq_ack_nxt;
    end
  end
`endif
endmodule
`default_nettype wire
